// File: rtl/accumulator_ctrl_if.sv
// Handshake and per-bank address/strobe bundle between the top-level controller
// and the accumulator bank sequencer.
interface accumulator_ctrl_if #(
   parameter int unsigned SYSTOLIC_SIZE = 8,
   parameter int unsigned ADDR_WIDTH    = 3
);
   logic                                start;
   logic                                test_mode;
   logic                                drain_ready;
   logic [SYSTOLIC_SIZE-1:0]            wr_en;
   logic [SYSTOLIC_SIZE*ADDR_WIDTH-1:0] wr_addr;
   logic [SYSTOLIC_SIZE*ADDR_WIDTH-1:0] rd_addr;
   logic [SYSTOLIC_SIZE-1:0]            rd_valid;
   logic                                busy;
   logic                                done;

   modport master (
      output start, test_mode, drain_ready,
      input  wr_en, wr_addr, rd_addr, rd_valid, busy, done
   );

   modport slave (
      input  start, test_mode, drain_ready,
      output wr_en, wr_addr, rd_addr, rd_valid, busy, done
   );
endinterface

// File: rtl/accumulator_ctrl.sv
// Sequencer for the per-column accumulator banks: skewed writes while the array
// streams out (FILL), then skewed or parallel reads to drain the banks (DRAIN).
module accumulator_ctrl #(
   parameter int unsigned SYSTOLIC_SIZE  = 8,
   parameter int unsigned PATTERN_NUMBER = 1,
   parameter int unsigned DEPTH          = PATTERN_NUMBER * SYSTOLIC_SIZE,
   parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH),
   parameter int unsigned CNT_WIDTH      = $clog2(DEPTH + SYSTOLIC_SIZE)
) (
   input logic               clk,
   input logic               rst,
   accumulator_ctrl_if.slave bus
);

   localparam int unsigned S      = SYSTOLIC_SIZE;
   localparam int unsigned AW     = ADDR_WIDTH;
   localparam int unsigned L_F    = DEPTH + S - 1;
   localparam logic [CNT_WIDTH-1:0] FILL_LAST    = CNT_WIDTH'(L_F - 1);
   localparam logic [CNT_WIDTH-1:0] DRAIN_LAST_N = CNT_WIDTH'(L_F - 1);
   localparam logic [CNT_WIDTH-1:0] DRAIN_LAST_T = CNT_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 mode_q, mode_d;

   logic [S-1:0]    wr_en_d, wr_en_q;
   logic [S*AW-1:0] wr_addr_d, wr_addr_q;
   logic [S-1:0]    rd_valid_d, rd_valid_q;
   logic [S*AW-1:0] rd_addr_d, rd_addr_q;
   logic            busy_d, busy_q;
   logic            done_d, done_q;

   logic [S-1:0]    in_win;
   logic [AW-1:0]   skew [S];

   // Next state / step counter; the counter restarts at zero on every state entry
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = FILL;
               cnt_d   = '0;
               mode_d  = bus.test_mode;
            end
         end
         FILL: begin
            if (cnt_q == FILL_LAST) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         DRAIN: begin
            if (bus.drain_ready) begin
               if (cnt_q == (mode_q ? DRAIN_LAST_T : DRAIN_LAST_N)) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Per-column 45-degree window and skewed address, evaluated on the next step count
   for (genvar c = 0; c < int'(S); c++) begin : g_col
      assign in_win[c] = (cnt_d >= CNT_WIDTH'(c)) && (cnt_d < CNT_WIDTH'(c + int'(DEPTH)));
      assign skew[c]   = AW'(cnt_d - CNT_WIDTH'(c));
   end

   // Output decode of the upcoming state so the registered outputs line up with it
   always_comb begin
      wr_en_d    = '0;
      wr_addr_d  = '0;
      rd_valid_d = '0;
      rd_addr_d  = '0;
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      for (int unsigned c = 0; c < S; c++) begin
         if (state_d == FILL && in_win[c]) begin
            wr_en_d[c]             = 1'b1;
            wr_addr_d[c*AW +: AW]  = skew[c];
         end
         if (state_d == DRAIN) begin
            if (mode_d) begin
               rd_valid_d[c]         = 1'b1;
               rd_addr_d[c*AW +: AW] = AW'(cnt_d);
            end else if (in_win[c]) begin
               rd_valid_d[c]         = 1'b1;
               rd_addr_d[c*AW +: AW] = skew[c];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mode_q     <= 1'b0;
         wr_en_q    <= '0;
         wr_addr_q  <= '0;
         rd_valid_q <= '0;
         rd_addr_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         rd_valid_q <= rd_valid_d;
         rd_addr_q  <= rd_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_addr  = rd_addr_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule
